// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets the Harvard core's fetch and data ports share one single-ported
// memory by granting them one transaction at a time and stalling the loser.
module mem_port_arbiter #(
   parameter logic DATA_PRIORITY = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_address,
   input  logic        instr_read,
   output logic [31:0] instr_readdata,
   output logic        instr_waitrequest,
   input  logic [31:0] data_address,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_writedata,
   input  logic [3:0]  data_byteenable,
   output logic [31:0] data_readdata,
   output logic        data_waitrequest,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_byteenable,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

   state_t state;
   state_t state_nxt;
   logic   last_grant;
   logic   last_grant_nxt;
   logic   resp_write;
   logic   resp_write_nxt;
   logic   instr_req;
   logic   data_req;
   logic   mem_accept;

   assign instr_req  = instr_read;
   assign data_req   = data_read | data_write;
   assign mem_accept = ~mem_waitrequest;

   // Shared by IDLE and RESP so a new grant can follow a completion without a bubble.
   function automatic state_t arbitrate(input logic i_req, input logic d_req, input logic lg);
      state_t s;
      s = IDLE;
      if (i_req && d_req) begin
         s = (DATA_PRIORITY || !lg) ? GNT_D : GNT_I;
      end else if (d_req) begin
         s = GNT_D;
      end else if (i_req) begin
         s = GNT_I;
      end
      return s;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b0;
         resp_write <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         resp_write <= resp_write_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      resp_write_nxt = resp_write;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_writedata  = '0;
      mem_byteenable = '0;
      instr_readdata = '0;
      data_readdata  = '0;
      case (state)
         IDLE: begin
            state_nxt = arbitrate(instr_req, data_req, last_grant);
         end
         GNT_I: begin
            mem_read       = 1'b1;
            mem_address    = instr_address;
            mem_byteenable = 4'b1111;
            if (mem_accept) begin
               state_nxt      = RESP;
               last_grant_nxt = 1'b0;
               resp_write_nxt = 1'b0;
            end
         end
         GNT_D: begin
            // A combined read+write request is treated as a store.
            mem_write      = data_write;
            mem_read       = data_read & ~data_write;
            mem_address    = data_address;
            mem_writedata  = data_writedata;
            mem_byteenable = data_byteenable;
            if (mem_accept) begin
               state_nxt      = RESP;
               last_grant_nxt = 1'b1;
               resp_write_nxt = data_write;
            end
         end
         RESP: begin
            if (!last_grant) begin
               instr_readdata = mem_readdata;
            end else if (!resp_write) begin
               data_readdata = mem_readdata;
            end
            state_nxt = arbitrate(instr_req, data_req, last_grant);
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign instr_waitrequest = instr_req & ~((state == RESP) & ~last_grant);
   assign data_waitrequest  = data_req & ~((state == RESP) & last_grant);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a word memory model, directed timing scenarios, randomized
// traffic scored against a reference memory, and a round-robin instance.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;

   logic [31:0] instr_address = '0;
   logic        instr_read = 1'b0;
   logic [31:0] instr_readdata;
   logic        instr_waitrequest;
   logic [31:0] data_address = '0;
   logic        data_read = 1'b0;
   logic        data_write = 1'b0;
   logic [31:0] data_writedata = '0;
   logic [3:0]  data_byteenable = '0;
   logic [31:0] data_readdata;
   logic        data_waitrequest;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata = '0;
   logic        mem_waitrequest;

   logic [31:0] p0_instr_address = '0;
   logic        p0_instr_read = 1'b0;
   logic [31:0] p0_instr_readdata;
   logic        p0_instr_waitrequest;
   logic [31:0] p0_data_address = '0;
   logic        p0_data_read = 1'b0;
   logic        p0_data_write = 1'b0;
   logic [31:0] p0_data_writedata = '0;
   logic [3:0]  p0_data_byteenable = '0;
   logic [31:0] p0_data_readdata;
   logic        p0_data_waitrequest;
   logic [31:0] p0_mem_address;
   logic        p0_mem_read;
   logic        p0_mem_write;
   logic [31:0] p0_mem_writedata;
   logic [3:0]  p0_mem_byteenable;
   logic [31:0] p0_mem_readdata = '0;
   logic        p0_mem_waitrequest = 1'b0;

   mem_port_arbiter #(.DATA_PRIORITY(1'b1)) dut (
      .clk(clk), .rst(rst),
      .instr_address(instr_address), .instr_read(instr_read),
      .instr_readdata(instr_readdata), .instr_waitrequest(instr_waitrequest),
      .data_address(data_address), .data_read(data_read), .data_write(data_write),
      .data_writedata(data_writedata), .data_byteenable(data_byteenable),
      .data_readdata(data_readdata), .data_waitrequest(data_waitrequest),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
   );

   mem_port_arbiter #(.DATA_PRIORITY(1'b0)) dut_rr (
      .clk(clk), .rst(rst),
      .instr_address(p0_instr_address), .instr_read(p0_instr_read),
      .instr_readdata(p0_instr_readdata), .instr_waitrequest(p0_instr_waitrequest),
      .data_address(p0_data_address), .data_read(p0_data_read), .data_write(p0_data_write),
      .data_writedata(p0_data_writedata), .data_byteenable(p0_data_byteenable),
      .data_readdata(p0_data_readdata), .data_waitrequest(p0_data_waitrequest),
      .mem_address(p0_mem_address), .mem_read(p0_mem_read), .mem_write(p0_mem_write),
      .mem_writedata(p0_mem_writedata), .mem_byteenable(p0_mem_byteenable),
      .mem_readdata(p0_mem_readdata), .mem_waitrequest(p0_mem_waitrequest)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic [31:0] exp_i_q [$];
   logic [31:0] exp_d_q [$];
   logic rand_mode = 1'b0;
   logic force_wait = 1'b0;
   logic rand_wait = 1'b0;
   int   stall_run = 0;
   logic both_strobes = 1'b0;

   assign mem_waitrequest = rand_mode ? rand_wait : force_wait;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory model: readdata registered on accept, byte-lane writes.
   always @(posedge clk) begin
      if (mem_read && !mem_waitrequest) mem_readdata <= mem[mem_address[7:2]];
      if (mem_write && !mem_waitrequest)
         mem[mem_address[7:2]] = merge(mem[mem_address[7:2]], mem_writedata, mem_byteenable);
      if (mem_read && mem_write) both_strobes <= 1'b1;
      if (rand_mode && stall_run < 2 && $urandom_range(0, 9) < 3) begin
         rand_wait <= 1'b1;
         stall_run <= stall_run + 1;
      end else begin
         rand_wait <= 1'b0;
         stall_run <= 0;
      end
   end

   always @(posedge clk) begin
      if (p0_mem_read && !p0_mem_waitrequest) p0_mem_readdata <= p0_mem_address ^ 32'h5A5A_0000;
   end

   // Scoreboard monitor: each completion pops the expectation pushed at issue.
   always @(negedge clk) begin
      if (!rst) begin
         if (instr_read && !instr_waitrequest) begin
            if (exp_i_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL instr_unexpected_completion: got %h, expected none", instr_readdata);
            end else chk("instr_readdata", instr_readdata, exp_i_q.pop_front());
         end
         if ((data_read || data_write) && !data_waitrequest) begin
            if (exp_d_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL data_unexpected_completion: got %h, expected none", data_readdata);
            end else chk("data_readdata", data_readdata, exp_d_q.pop_front());
         end
      end
   end

   task automatic wait_done_i(input string name);
      int n = 0;
      do begin @(negedge clk); #1; n++; end while (instr_waitrequest && n < 200);
      if (instr_waitrequest) begin
         checks++; errors++;
         $display("FAIL %s: timeout, waitrequest still %b, expected 0", name, instr_waitrequest);
      end
   endtask

   task automatic wait_done_d(input string name);
      int n = 0;
      do begin @(negedge clk); #1; n++; end while (data_waitrequest && n < 200);
      if (data_waitrequest) begin
         checks++; errors++;
         $display("FAIL %s: timeout, waitrequest still %b, expected 0", name, data_waitrequest);
      end
   endtask

   task automatic instr_driver(input int n);
      for (int k = 0; k < n; k++) begin
         int gap;
         int idx;
         gap = $urandom_range(0, 3);
         idx = $urandom_range(0, 31);
         if (gap > 0) begin instr_read = 1'b0; repeat (gap) @(negedge clk); #2; end
         instr_address = 32'(idx * 4);
         instr_read = 1'b1;
         exp_i_q.push_back(ref_mem[idx]);
         wait_done_i("instr_rand");
         #1;
      end
      instr_read = 1'b0;
   endtask

   task automatic data_driver(input int n);
      for (int k = 0; k < n; k++) begin
         int gap;
         int idx;
         int op;
         logic [31:0] wd;
         logic [3:0] be;
         gap = $urandom_range(0, 3);
         idx = $urandom_range(32, 63);
         op  = $urandom_range(0, 9);
         wd  = $urandom;
         be  = 4'($urandom_range(1, 15));
         if (gap > 0) begin data_read = 1'b0; data_write = 1'b0; repeat (gap) @(negedge clk); #2; end
         data_address = 32'(idx * 4);
         data_writedata = wd;
         data_byteenable = be;
         data_write = (op >= 5);
         data_read = (op < 5) || (op == 9);
         if (data_write) begin
            ref_mem[idx] = merge(ref_mem[idx], wd, be);
            exp_d_q.push_back(32'h0);
         end else exp_d_q.push_back(ref_mem[idx]);
         wait_done_d("data_rand");
         #1;
      end
      data_read = 1'b0;
      data_write = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] old8;
      int order [$];
      for (int i = 0; i < 64; i++) begin ref_mem[i] = $urandom; mem[i] = ref_mem[i]; end
      ref_mem[4] = 32'h2402_0005;
      mem[4] = 32'h2402_0005;
      old8 = ref_mem[8];

      repeat (2) @(negedge clk);
      chk("rst_mem_read", 32'(mem_read), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_byteenable", 32'(mem_byteenable), 0);
      chk("rst_instr_wait", 32'(instr_waitrequest), 0);
      chk("rst_data_wait", 32'(data_waitrequest), 0);
      chk("rst_instr_rdata", instr_readdata, 0);
      chk("rst_data_rdata", data_readdata, 0);
      #2 rst = 1'b0;
      @(negedge clk); #2;

      // Fetch only: strobe one cycle after the request, completion the cycle after.
      instr_address = 32'h10; instr_read = 1'b1; exp_i_q.push_back(32'h2402_0005);
      @(negedge clk);
      chk("t1_mem_read", 32'(mem_read), 1);
      chk("t1_mem_address", mem_address, 32'h10);
      chk("t1_mem_be", 32'(mem_byteenable), 32'hF);
      chk("t1_instr_wait_n1", 32'(instr_waitrequest), 1);
      @(negedge clk);
      chk("t1_instr_wait_n2", 32'(instr_waitrequest), 0);
      chk("t1_instr_rdata", instr_readdata, 32'h2402_0005);
      #2 instr_read = 1'b0;
      @(negedge clk); #2;

      // Collision with data priority: store first, fetch one grant later.
      instr_address = 32'h0C; instr_read = 1'b1; exp_i_q.push_back(ref_mem[3]);
      data_address = 32'h20; data_write = 1'b1; data_writedata = 32'hDEAD_BEEF;
      data_byteenable = 4'b0011; exp_d_q.push_back(32'h0);
      ref_mem[8] = merge(ref_mem[8], 32'hDEAD_BEEF, 4'b0011);
      @(negedge clk);
      chk("t2_mem_write", 32'(mem_write), 1);
      chk("t2_mem_read", 32'(mem_read), 0);
      chk("t2_mem_address", mem_address, 32'h20);
      chk("t2_mem_wdata", mem_writedata, 32'hDEAD_BEEF);
      chk("t2_mem_be", 32'(mem_byteenable), 32'h3);
      @(negedge clk);
      chk("t2_data_wait", 32'(data_waitrequest), 0);
      chk("t2_instr_wait_held", 32'(instr_waitrequest), 1);
      #2 data_write = 1'b0;
      @(negedge clk);
      chk("t2_fetch_strobe", 32'(mem_read), 1);
      chk("t2_fetch_addr", mem_address, 32'h0C);
      @(negedge clk);
      chk("t2_instr_done", 32'(instr_waitrequest), 0);
      #2 instr_read = 1'b0;
      chk("t2_mem_word", mem[8], {old8[31:16], 16'hBEEF});
      @(negedge clk); #2;

      // Read and write together: only the store is issued.
      data_address = 32'h84; data_read = 1'b1; data_write = 1'b1;
      data_writedata = 32'h1234_5678; data_byteenable = 4'hF; exp_d_q.push_back(32'h0);
      ref_mem[33] = 32'h1234_5678;
      @(negedge clk);
      chk("t6_mem_write", 32'(mem_write), 1);
      chk("t6_mem_read", 32'(mem_read), 0);
      @(negedge clk);
      chk("t6_data_wait", 32'(data_waitrequest), 0);
      chk("t6_data_rdata", data_readdata, 0);
      #2 data_read = 1'b0; data_write = 1'b0;
      @(negedge clk); #2;

      // Three memory stall cycles during a fetch grant; a load waits behind it.
      force_wait = 1'b1;
      instr_address = 32'h14; instr_read = 1'b1; exp_i_q.push_back(ref_mem[5]);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk("t4_mem_read", 32'(mem_read), 1);
         chk("t4_mem_address", mem_address, 32'h14);
         chk("t4_instr_wait", 32'(instr_waitrequest), 1);
         if (c >= 2) chk("t4_data_wait", 32'(data_waitrequest), 1);
         if (c == 1) begin
            #2 data_address = 32'h88; data_read = 1'b1; exp_d_q.push_back(ref_mem[34]);
         end
         if (c == 4) #2 force_wait = 1'b0;
      end
      @(negedge clk);
      chk("t4_instr_done", 32'(instr_waitrequest), 0);
      chk("t4_data_wait_resp", 32'(data_waitrequest), 1);
      #2 instr_read = 1'b0;
      @(negedge clk);
      chk("t4_load_strobe", 32'(mem_read), 1);
      chk("t4_load_addr", mem_address, 32'h88);
      @(negedge clk);
      chk("t4_load_done", 32'(data_waitrequest), 0);
      #2 data_read = 1'b0;
      @(negedge clk); #2;

      // Async reset in the middle of a stalled store.
      force_wait = 1'b1;
      data_address = 32'h8C; data_write = 1'b1; data_writedata = 32'hCAFE_F00D;
      data_byteenable = 4'hF; exp_d_q.push_back(32'h0);
      @(negedge clk);
      chk("t5_mem_write_before", 32'(mem_write), 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_mem_write_rst", 32'(mem_write), 0);
      chk("t5_mem_address_rst", mem_address, 0);
      chk("t5_mem_wdata_rst", mem_writedata, 0);
      chk("t5_mem_be_rst", 32'(mem_byteenable), 0);
      data_write = 1'b0;
      exp_d_q.delete();
      @(negedge clk); #2;
      rst = 1'b0; force_wait = 1'b0;
      @(negedge clk);
      chk("t5_idle_read", 32'(mem_read), 0);
      chk("t5_idle_write", 32'(mem_write), 0);
      #2 instr_address = 32'h18; instr_read = 1'b1; exp_i_q.push_back(ref_mem[6]);
      @(negedge clk);
      chk("t5_next_strobe", 32'(mem_read), 1);
      chk("t5_next_addr", mem_address, 32'h18);
      @(negedge clk);
      chk("t5_next_done", 32'(instr_waitrequest), 0);
      #2 instr_read = 1'b0;
      @(negedge clk); #2;

      // Randomized concurrent traffic with random memory stalls.
      rand_mode = 1'b1;
      fork
         instr_driver(60);
         data_driver(60);
      join
      rand_mode = 1'b0;
      repeat (4) @(negedge clk);
      chk("instr_queue_empty", exp_i_q.size(), 0);
      chk("data_queue_empty", exp_d_q.size(), 0);
      chk("never_both_strobes", 32'(both_strobes), 0);
      for (int i = 0; i < 64; i++) chk("mem_contents", mem[i], ref_mem[i]);

      // Round-robin instance: both ports request continuously for eight transactions.
      #2;
      p0_instr_address = 32'h100; p0_instr_read = 1'b1;
      p0_data_address = 32'h200; p0_data_read = 1'b1;
      for (int c = 0; c < 40 && order.size() < 8; c++) begin
         @(negedge clk);
         if (p0_data_read && !p0_data_waitrequest) begin
            order.push_back(1);
            chk("rr_data_rdata", p0_data_readdata, 32'h5A5A_0200);
         end
         if (p0_instr_read && !p0_instr_waitrequest) begin
            order.push_back(0);
            chk("rr_instr_rdata", p0_instr_readdata, 32'h5A5A_0100);
         end
      end
      #2 p0_instr_read = 1'b0; p0_data_read = 1'b0;
      chk("rr_count", order.size(), 8);
      foreach (order[k]) chk("rr_order", order[k], (k % 2 == 0) ? 1 : 0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
